// File: rtl/capture_trigger_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : capture_trigger_ctrl
//  Brief    : Trigger controller for a logic-analyser style stream capture.
//             It spies on a valid/ready stream and passes beats through to a
//             capture buffer from arm until a programmable number of beats
//             after a masked data match or a forced trigger.
//             Configuration and status are reached over an APB slave port.
//  Revision : 1.0 - initial release
// ============================================================================
module capture_trigger_ctrl #(
    parameter int DataBits  = 8,
    parameter int CountBits = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // Spied stream (observed only)
    input  logic [DataBits-1:0]  din_data,
    input  logic                 din_valid,
    input  logic                 din_ready,
    // Gated stream toward the capture buffer
    output logic [DataBits-1:0]  cap_data,
    output logic                 cap_valid,
    output logic                 cap_ready,
    output logic                 done,
    // APB configuration slave
    input  logic [4:0]           cfg_paddr,
    input  logic                 cfg_psel,
    input  logic                 cfg_penable,
    input  logic                 cfg_pwrite,
    input  logic [31:0]          cfg_pwdata,
    output logic                 cfg_pready,
    output logic [31:0]          cfg_prdata,
    output logic                 cfg_pslverr
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ARMED = 2'd1;
    localparam logic [1:0] c_POST  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [2:0] c_A_CTRL   = 3'd0;
    localparam logic [2:0] c_A_STATUS = 3'd1;
    localparam logic [2:0] c_A_VALUE  = 3'd2;
    localparam logic [2:0] c_A_MASK   = 3'd3;
    localparam logic [2:0] c_A_POST   = 3'd4;
    localparam logic [2:0] c_A_POS    = 3'd5;
    localparam logic [2:0] c_A_COUNT  = 3'd6;

    localparam logic [CountBits-1:0] c_CNT_MAX = {CountBits{1'b1}};
    localparam logic [CountBits-1:0] c_CNT_ONE = CountBits'(1);

    logic [1:0]           r_state;
    logic [DataBits-1:0]  r_trig_value;
    logic [DataBits-1:0]  r_trig_mask;
    logic [CountBits-1:0] r_post_count;
    logic [CountBits-1:0] r_trig_pos;
    logic [CountBits-1:0] r_cap_count;
    logic [CountBits-1:0] r_remaining;
    logic                 r_trig_seen;
    logic                 r_done;
    logic                 r_pready;
    logic [31:0]          r_prdata;

    logic        w_setup;
    logic        w_wr;
    logic [2:0]  w_addr;
    logic        w_arm;
    logic        w_abort;
    logic        w_force;
    logic        w_txn;
    logic        w_active;
    logic        w_gated;
    logic        w_match;
    logic        w_trigger;
    logic [31:0] w_rdata;
    logic        w_unused_bits;

    // Low address bits are byte lanes and not every data bit lands in a register.
    assign w_unused_bits = ^{cfg_paddr[1:0], cfg_pwdata};

    // An APB access is taken in its setup phase; CTRL bits act as one-shot strobes.
    assign w_setup = cfg_psel && !cfg_penable;
    assign w_wr    = w_setup && cfg_pwrite;
    assign w_addr  = cfg_paddr[4:2];
    assign w_arm   = w_wr && (w_addr == c_A_CTRL) && cfg_pwdata[0];
    assign w_abort = w_wr && (w_addr == c_A_CTRL) && cfg_pwdata[1];
    assign w_force = w_wr && (w_addr == c_A_CTRL) && cfg_pwdata[2];

    assign w_txn     = din_valid && din_ready;
    assign w_active  = (r_state == c_ARMED) || (r_state == c_POST);
    assign w_gated   = w_active && w_txn;
    assign w_match   = ((din_data ^ r_trig_value) & r_trig_mask) == '0;
    assign w_trigger = (r_state == c_ARMED) && (w_force || (w_txn && w_match));

    // Zero-latency pass-through while a capture window is open.
    assign cap_valid = w_active && din_valid;
    assign cap_ready = w_active && din_ready;
    assign cap_data  = w_active ? din_data : '0;

    assign done        = r_done;
    assign cfg_pready  = r_pready;
    assign cfg_prdata  = r_prdata;
    assign cfg_pslverr = 1'b0;

    // Read mux; CTRL and the unused slot read back as zero.
    always_comb begin
        w_rdata = 32'd0;
        case (w_addr)
            c_A_STATUS: w_rdata = {29'd0, r_trig_seen, r_state};
            c_A_VALUE:  w_rdata = 32'(r_trig_value);
            c_A_MASK:   w_rdata = 32'(r_trig_mask);
            c_A_POST:   w_rdata = 32'(r_post_count);
            c_A_POS:    w_rdata = 32'(r_trig_pos);
            c_A_COUNT:  w_rdata = 32'(r_cap_count);
            default:    w_rdata = 32'd0;
        endcase
    end

    // APB response: ready pulses one cycle after setup, carrying the read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pready <= 1'b0;
            r_prdata <= 32'd0;
        end else begin
            r_pready <= w_setup;
            r_prdata <= (w_setup && !cfg_pwrite) ? w_rdata : 32'd0;
        end
    end

    // Trigger configuration registers; a write only affects later beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trig_value <= '0;
            r_trig_mask  <= '0;
            r_post_count <= '0;
        end else if (w_wr) begin
            if (w_addr == c_A_VALUE) r_trig_value <= cfg_pwdata[DataBits-1:0];
            if (w_addr == c_A_MASK)  r_trig_mask  <= cfg_pwdata[DataBits-1:0];
            if (w_addr == c_A_POST)  r_post_count <= cfg_pwdata[CountBits-1:0];
        end
    end

    // Capture state machine with beat counter, trigger position and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_trig_pos  <= '0;
            r_cap_count <= '0;
            r_remaining <= '0;
            r_trig_seen <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Every beat that passes the gate is counted, saturating at all-ones.
            if (w_gated && (r_cap_count != c_CNT_MAX)) begin
                r_cap_count <= r_cap_count + c_CNT_ONE;
            end
            if (w_abort) begin
                r_state <= c_IDLE;
            end else begin
                case (r_state)
                    c_IDLE, c_DONE: begin
                        if (w_arm) begin
                            r_state     <= c_ARMED;
                            r_cap_count <= '0;
                            r_trig_pos  <= '0;
                            r_trig_seen <= 1'b0;
                        end
                    end
                    c_ARMED: begin
                        if (w_trigger) begin
                            // Position is the count before the triggering beat.
                            r_trig_pos  <= r_cap_count;
                            r_remaining <= r_post_count;
                            r_trig_seen <= 1'b1;
                            if (r_post_count == '0) begin
                                r_state <= c_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= c_POST;
                            end
                        end
                    end
                    c_POST: begin
                        if (w_txn) begin
                            r_remaining <= r_remaining - c_CNT_ONE;
                            if (r_remaining == c_CNT_ONE) begin
                                r_state <= c_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_capture_trigger_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_capture_trigger_ctrl
//  Brief    : Self-checking bench for capture_trigger_ctrl: directed capture
//             scenarios with literal expectations followed by randomized
//             stream and APB traffic against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_capture_trigger_ctrl;

    localparam int unsigned c_MAXC = 65535;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  din_data = '0;
    logic        din_valid = 1'b0;
    logic        din_ready = 1'b0;
    logic [7:0]  cap_data;
    logic        cap_valid;
    logic        cap_ready;
    logic        done;
    logic [4:0]  cfg_paddr = '0;
    logic        cfg_psel = 1'b0;
    logic        cfg_penable = 1'b0;
    logic        cfg_pwrite = 1'b0;
    logic [31:0] cfg_pwdata = '0;
    logic        cfg_pready;
    logic [31:0] cfg_prdata;
    logic        cfg_pslverr;

    always #5 clk = ~clk;

    capture_trigger_ctrl #(.DataBits(8), .CountBits(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din_data    (din_data),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .cap_data    (cap_data),
        .cap_valid   (cap_valid),
        .cap_ready   (cap_ready),
        .done        (done),
        .cfg_paddr   (cfg_paddr),
        .cfg_psel    (cfg_psel),
        .cfg_penable (cfg_penable),
        .cfg_pwrite  (cfg_pwrite),
        .cfg_pwdata  (cfg_pwdata),
        .cfg_pready  (cfg_pready),
        .cfg_prdata  (cfg_prdata),
        .cfg_pslverr (cfg_pslverr)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_done = 0;
    logic [7:0] q_cap[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_state = 0;   // 0 idle, 1 armed, 2 post, 3 done
    logic [7:0]  m_val = '0;
    logic [7:0]  m_mask = '0;
    int unsigned m_post = 0;
    int unsigned m_pos = 0;
    int unsigned m_cnt = 0;
    int unsigned m_rem = 0;
    bit          m_seen = 0;
    bit          m_done = 0;
    bit          m_pready = 0;
    logic [31:0] m_prdata = '0;

    function automatic logic [31:0] model_read(input int a);
        case (a)
            1: return {29'd0, m_seen, 2'(m_state)};
            2: return {24'd0, m_val};
            3: return {24'd0, m_mask};
            4: return m_post;
            5: return m_pos;
            6: return m_cnt;
            default: return 32'd0;
        endcase
    endfunction

    // Compare on the falling edge, then advance the model to the next cycle.
    always @(negedge clk) begin : b_model
        bit          setup, wr, arm, abort_c, force_c, txn, active, hit;
        int          a;
        int unsigned old_cnt;
        if (!rst_n) begin
            m_state = 0; m_val = '0; m_mask = '0; m_post = 0; m_pos = 0;
            m_cnt = 0; m_rem = 0; m_seen = 0; m_done = 0; m_pready = 0; m_prdata = '0;
        end
        active = (m_state == 1) || (m_state == 2);
        chk("cap_valid", {31'd0, cap_valid}, {31'd0, active && din_valid});
        chk("cap_ready", {31'd0, cap_ready}, {31'd0, active && din_ready});
        chk("cap_data", {24'd0, cap_data}, active ? {24'd0, din_data} : 32'd0);
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("pready", {31'd0, cfg_pready}, {31'd0, m_pready});
        chk("prdata", cfg_prdata, m_prdata);
        chk("pslverr", {31'd0, cfg_pslverr}, 32'd0);
        if (cap_valid && cap_ready) q_cap.push_back(cap_data);
        if (done) n_done++;
        if (rst_n) begin
            setup   = cfg_psel && !cfg_penable;
            wr      = setup && cfg_pwrite;
            a       = int'(cfg_paddr[4:2]);
            arm     = wr && (a == 0) && cfg_pwdata[0];
            abort_c = wr && (a == 0) && cfg_pwdata[1];
            force_c = wr && (a == 0) && cfg_pwdata[2];
            txn     = din_valid && din_ready;
            m_pready = setup;
            m_prdata = (setup && !cfg_pwrite) ? model_read(a) : 32'd0;
            m_done   = 0;
            old_cnt  = m_cnt;
            if (active && txn && m_cnt < c_MAXC) m_cnt = m_cnt + 1;
            if (abort_c) begin
                m_state = 0;
            end else if (m_state == 0 || m_state == 3) begin
                if (arm) begin
                    m_state = 1; m_cnt = 0; m_pos = 0; m_seen = 0;
                end
            end else if (m_state == 1) begin
                hit = force_c || (txn && (((din_data ^ m_val) & m_mask) == 8'd0));
                if (hit) begin
                    m_pos = old_cnt; m_seen = 1;
                    if (m_post == 0) begin
                        m_state = 3; m_done = 1;
                    end else begin
                        m_rem = m_post; m_state = 2;
                    end
                end
            end else begin
                if (txn) begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) begin
                        m_state = 3; m_done = 1;
                    end
                end
            end
            if (wr && a == 2) m_val  = cfg_pwdata[7:0];
            if (wr && a == 3) m_mask = cfg_pwdata[7:0];
            if (wr && a == 4) m_post = {16'd0, cfg_pwdata[15:0]};
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apb(input bit wr, input logic [4:0] a, input logic [31:0] d, output logic [31:0] rd);
        tick();
        din_valid = 1'b0;
        cfg_psel = 1'b1; cfg_penable = 1'b0; cfg_pwrite = wr; cfg_paddr = a; cfg_pwdata = d;
        tick();
        cfg_penable = 1'b1;
        @(negedge clk);
        rd = cfg_prdata;
        tick();
        cfg_psel = 1'b0; cfg_penable = 1'b0;
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        apb(1'b1, a, d, dummy);
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] r;
        apb(1'b0, a, 32'd0, r);
        chk(name, r, exp);
    endtask

    task automatic beat(input bit v, input bit r, input logic [7:0] d);
        tick();
        din_valid = v; din_ready = r; din_data = d;
    endtask

    logic [7:0] e1[8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA5, 8'h10, 8'h11, 8'h12};
    logic [7:0] s1[10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA5, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14};

    initial begin
        int ph;
        int a;
        int pick;
        int done_before;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        rd_chk("reset_status", 5'h04, 32'd0);
        rd_chk("reset_count", 5'h18, 32'd0);

        // Match on 0xA5 with three post-trigger beats
        wr_reg(5'h08, 32'hA5);
        wr_reg(5'h0C, 32'hFF);
        wr_reg(5'h10, 32'd3);
        q_cap.delete(); n_done = 0;
        wr_reg(5'h00, 32'd1);
        foreach (s1[i]) beat(1'b1, 1'b1, s1[i]);
        beat(1'b0, 1'b0, 8'h00);
        tick();
        chk("t1_beats", q_cap.size(), 32'd8);
        foreach (e1[i]) if (i < q_cap.size()) chk("t1_beat_data", {24'd0, q_cap[i]}, {24'd0, e1[i]});
        chk("t1_done_count", n_done, 32'd1);
        rd_chk("t1_trig_pos", 5'h14, 32'd4);
        rd_chk("t1_cap_count", 5'h18, 32'd8);
        rd_chk("t1_status", 5'h04, 32'h7);

        // Mask zero, no post beats: first beat triggers and ends capture
        wr_reg(5'h0C, 32'h0);
        wr_reg(5'h10, 32'd0);
        q_cap.delete(); n_done = 0;
        wr_reg(5'h00, 32'd1);
        beat(1'b1, 1'b1, 8'h33);
        tick();
        din_valid = 1'b0;
        @(negedge clk);
        chk("t2_done_pulse", {31'd0, done}, 32'd1);
        beat(1'b1, 1'b1, 8'h44);
        beat(1'b0, 1'b0, 8'h00);
        chk("t2_beats", q_cap.size(), 32'd1);
        if (q_cap.size() > 0) chk("t2_beat_data", {24'd0, q_cap[0]}, 32'h33);
        rd_chk("t2_trig_pos", 5'h14, 32'd0);
        rd_chk("t2_status", 5'h04, 32'h7);

        // Forced trigger in an idle stream cycle
        wr_reg(5'h0C, 32'hFF);
        wr_reg(5'h10, 32'd2);
        q_cap.delete(); n_done = 0;
        wr_reg(5'h00, 32'd1);
        repeat (5) beat(1'b1, 1'b1, 8'h00);
        beat(1'b0, 1'b0, 8'h00);
        wr_reg(5'h00, 32'd4);
        repeat (4) beat(1'b1, 1'b1, 8'h00);
        beat(1'b0, 1'b0, 8'h00);
        rd_chk("t3_trig_pos", 5'h14, 32'd5);
        rd_chk("t3_cap_count", 5'h18, 32'd7);
        chk("t3_beats", q_cap.size(), 32'd7);
        chk("t3_done_count", n_done, 32'd1);

        // Abort together with arm
        q_cap.delete(); n_done = 0;
        wr_reg(5'h00, 32'd1);
        repeat (3) beat(1'b1, 1'b1, 8'h00);
        beat(1'b0, 1'b0, 8'h00);
        wr_reg(5'h00, 32'd3);
        rd_chk("t4_status", 5'h04, 32'd0);
        repeat (3) beat(1'b1, 1'b1, 8'hA5);
        beat(1'b0, 1'b0, 8'h00);
        chk("t4_beats", q_cap.size(), 32'd3);
        chk("t4_done_count", n_done, 32'd0);
        rd_chk("t4_cap_count", 5'h18, 32'd3);

        // Valid without ready is not a transaction
        wr_reg(5'h00, 32'd1);
        beat(1'b1, 1'b0, 8'hA5);
        beat(1'b1, 1'b0, 8'hA5);
        beat(1'b0, 1'b0, 8'h00);
        rd_chk("t5_status", 5'h04, 32'h1);
        rd_chk("t5_cap_count", 5'h18, 32'd0);

        // Reset in the middle of the post-trigger window
        wr_reg(5'h10, 32'd5);
        n_done = 0;
        beat(1'b1, 1'b1, 8'hA5);
        beat(1'b1, 1'b1, 8'h01);
        beat(1'b0, 1'b0, 8'h00);
        rd_chk("t6_status_post", 5'h04, 32'h6);
        tick();
        rst_n = 1'b0; din_valid = 1'b1; din_ready = 1'b1; din_data = 8'h07;
        #1;
        chk("t6_cap_valid_in_reset", {31'd0, cap_valid}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1; din_valid = 1'b0;
        rd_chk("t6_status", 5'h04, 32'd0);
        rd_chk("t6_value", 5'h08, 32'd0);
        rd_chk("t6_mask", 5'h0C, 32'd0);
        rd_chk("t6_post", 5'h10, 32'd0);
        rd_chk("t6_trig_pos", 5'h14, 32'd0);
        rd_chk("t6_cap_count", 5'h18, 32'd0);
        chk("t6_done_count", n_done, 32'd0);

        // Randomized traffic checked by the model every cycle
        ph = 0;
        for (int c = 0; c < 6000; c++) begin
            tick();
            rst_n     = ($urandom_range(0, 1499) != 0);
            din_valid = ($urandom_range(0, 3) != 0);
            din_ready = ($urandom_range(0, 3) != 0);
            din_data  = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
            case (ph)
                0: if ($urandom_range(0, 2) == 0) begin
                    a = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 7));
                    cfg_psel = 1'b1; cfg_penable = 1'b0;
                    cfg_paddr = {3'(a), 2'b00};
                    cfg_pwrite = (a == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                    pick = int'($urandom_range(0, 9));
                    case (a)
                        0: cfg_pwdata = (pick < 6) ? 32'd1 : (pick < 8) ? 32'd4 :
                                        (pick == 8) ? 32'd2 : 32'($urandom_range(0, 7));
                        2: cfg_pwdata = (pick < 5) ? 32'hA5 : {24'd0, 8'($urandom)};
                        3: cfg_pwdata = (pick < 4) ? 32'hFF : (pick < 6) ? 32'h0 :
                                        (pick < 8) ? 32'hF0 : {24'd0, 8'($urandom)};
                        4: cfg_pwdata = 32'($urandom_range(0, 6));
                        default: cfg_pwdata = $urandom;
                    endcase
                    ph = 1;
                end
                1: begin cfg_penable = 1'b1; ph = 2; end
                default: begin cfg_psel = 1'b0; cfg_penable = 1'b0; ph = 0; end
            endcase
        end
        tick();
        rst_n = 1'b1; cfg_psel = 1'b0; cfg_penable = 1'b0; din_valid = 1'b0;
        done_before = n_done;
        repeat (3) tick();
        chk("final_no_spurious_done", n_done, done_before);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
